// File: rtl/cam_yuv_packer_pkg.sv
// rtl/cam_yuv_packer_pkg.sv - shared phase/state encodings and default geometry
package cam_yuv_packer_pkg;

  localparam int DEF_H_PAIRS = 320;
  localparam int DEF_V_LINES = 480;

  localparam logic [1:0] PH_U  = 2'd0;
  localparam logic [1:0] PH_Y1 = 2'd1;
  localparam logic [1:0] PH_V  = 2'd2;
  localparam logic [1:0] PH_Y2 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/cam_yuv_packer_if.sv
// rtl/cam_yuv_packer_if.sv - camera byte stream in, packed UYVY quad out
interface cam_yuv_packer_if;
  logic [7:0] camdata;
  logic       href;
  logic       vsync;
  logic [7:0] u;
  logic [7:0] v;
  logic [7:0] y1;
  logic [7:0] y2;
  logic       pixvalid;
  logic       framestart;
  logic       linestart;

  modport master (
    output camdata, href, vsync,
    input  u, v, y1, y2, pixvalid, framestart, linestart
  );

  modport slave (
    input  camdata, href, vsync,
    output u, v, y1, y2, pixvalid, framestart, linestart
  );
endinterface

// File: rtl/cam_yuv_packer_sync_edge.sv
// rtl/cam_yuv_packer_sync_edge.sv - cam_sync_edge: HREF/VSYNC edge strobes
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic href,
  input  logic vsync,
  output logic href_rise,
  output logic href_fall,
  output logic vsync_rise,
  output logic vsync_fall
);

  logic href_q, href_d;
  logic vsync_q, vsync_d;

  always_comb begin
    href_d  = href;
    vsync_d = vsync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= href_d;
      vsync_q <= vsync_d;
    end
  end

  assign href_rise  = href & ~href_q;
  assign href_fall  = ~href & href_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;

endmodule

// File: rtl/cam_yuv_packer.sv
// rtl/cam_yuv_packer.sv - UYVY byte stream to quad packer; CAM_YUV_PACKER_CHECK_EN adds framing checks
module cam_yuv_packer
  import cam_yuv_packer_pkg::*;
#(
  parameter int H_PAIRS = DEF_H_PAIRS,
  parameter int V_LINES = DEF_V_LINES
) (
  input  logic             clk,
  input  logic             rst,
  cam_yuv_packer_if.slave  bus,
  input  logic             errclr,
  output logic             err
);

  localparam int PW = $clog2(H_PAIRS + 1);
  localparam int LW = $clog2(V_LINES + 1);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [LW-1:0] line_q, line_d;
  logic [7:0] u_h_q, u_h_d, y1_h_q, y1_h_d, v_h_q, v_h_d;
  logic [7:0] u_q, u_d, y1_q, y1_d, v_q, v_d, y2_q, y2_d;
  logic       pixvalid_q, pixvalid_d, fs_q, fs_d, ls_q, ls_d;
  logic       href_rise, href_fall, vsync_rise, vsync_fall;
  logic       sample, arm;

  cam_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .href       (bus.href),
    .vsync      (bus.vsync),
    .href_rise  (href_rise),
    .href_fall  (href_fall),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall)
  );

  assign sample = (state_q != ST_IDLE) && bus.href && !bus.vsync;
  assign arm    = (state_q == ST_IDLE) && vsync_fall;

  always_comb begin
    state_d = state_q;
    if (bus.vsync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (vsync_fall) state_d = ST_ARMED;
        ST_ARMED: if (bus.href)   state_d = ST_ACTIVE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    phase_d    = phase_q;
    pair_d     = pair_q;
    line_d     = line_q;
    u_h_d      = u_h_q;
    y1_h_d     = y1_h_q;
    v_h_d      = v_h_q;
    u_d        = u_q;
    y1_d       = y1_q;
    v_d        = v_q;
    y2_d       = y2_q;
    pixvalid_d = 1'b0;
    fs_d       = 1'b0;
    ls_d       = 1'b0;

    // VSYNC and the end of a line both throw away any partial quad
    if (bus.vsync || href_fall) begin
      phase_d = PH_U;
    end else if (sample) begin
      phase_d = phase_q + 2'd1;
    end

    if (sample) begin
      case (phase_q)
        PH_U:    u_h_d  = bus.camdata;
        PH_Y1:   y1_h_d = bus.camdata;
        PH_V:    v_h_d  = bus.camdata;
        default: begin
          u_d        = u_h_q;
          y1_d       = y1_h_q;
          v_d        = v_h_q;
          y2_d       = bus.camdata;
          pixvalid_d = 1'b1;
          ls_d       = (pair_q == '0);
          fs_d       = (pair_q == '0) && (line_q == '0);
          if (pair_q != PW'(H_PAIRS)) pair_d = pair_q + PW'(1);
        end
      endcase
    end

    if (href_fall) begin
      pair_d = '0;
      if (state_q != ST_IDLE && line_q != LW'(V_LINES)) line_d = line_q + LW'(1);
    end

    if (arm) begin
      pair_d = '0;
      line_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_U;
      pair_q     <= '0;
      line_q     <= '0;
      u_h_q      <= '0;
      y1_h_q     <= '0;
      v_h_q      <= '0;
      u_q        <= '0;
      y1_q       <= '0;
      v_q        <= '0;
      y2_q       <= '0;
      pixvalid_q <= 1'b0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pair_q     <= pair_d;
      line_q     <= line_d;
      u_h_q      <= u_h_d;
      y1_h_q     <= y1_h_d;
      v_h_q      <= v_h_d;
      u_q        <= u_d;
      y1_q       <= y1_d;
      v_q        <= v_d;
      y2_q       <= y2_d;
      pixvalid_q <= pixvalid_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
    end
  end

  assign bus.u          = u_q;
  assign bus.y1         = y1_q;
  assign bus.v          = v_q;
  assign bus.y2         = y2_q;
  assign bus.pixvalid   = pixvalid_q;
  assign bus.framestart = fs_q;
  assign bus.linestart  = ls_q;

`ifdef CAM_YUV_PACKER_CHECK_EN
  logic err_q, err_d, err_set;
  logic unused_href_rise;

  assign unused_href_rise = href_rise;

  // Set wins over a same-cycle clear so no framing error is ever lost
  always_comb begin
    err_set = ((state_q != ST_IDLE) && href_fall &&
               ((phase_q != PH_U) || (pair_q != PW'(H_PAIRS)))) ||
              ((state_q == ST_ACTIVE) && vsync_rise && (line_q != LW'(V_LINES)));
    err_d   = err_set | (err_q & ~errclr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_inputs;

  assign unused_inputs = href_rise ^ vsync_rise ^ errclr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_yuv_packer.sv
// tb/tb_cam_yuv_packer.sv - scoreboard bench for cam_yuv_packer (H_PAIRS=4, V_LINES=2)
module tb_cam_yuv_packer;

  typedef struct {
    logic [7:0] u;
    logic [7:0] y1;
    logic [7:0] v;
    logic [7:0] y2;
    logic       fs;
    logic       ls;
  } exp_t;

`ifdef CAM_YUV_PACKER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic errclr = 1'b0;
  logic err;
  int   total = 0;
  int   bad = 0;
  int   pix_cnt = 0;
  int   snap;
  exp_t sb[$];

  cam_yuv_packer_if bus();

  cam_yuv_packer #(.H_PAIRS(4), .V_LINES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .errclr (errclr),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.pixvalid) begin
      exp_t e;
      pix_cnt++;
      check("pix_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("u",  {24'd0, bus.u},  {24'd0, e.u});
        check("y1", {24'd0, bus.y1}, {24'd0, e.y1});
        check("v",  {24'd0, bus.v},  {24'd0, e.v});
        check("y2", {24'd0, bus.y2}, {24'd0, e.y2});
        check("framestart", {31'd0, bus.framestart}, {31'd0, e.fs});
        check("linestart",  {31'd0, bus.linestart},  {31'd0, e.ls});
      end
    end
  end

  task automatic cyc(input logic [7:0] d, input logic h, input logic vs);
    @(posedge clk);
    #1;
    bus.camdata = d;
    bus.href    = h;
    bus.vsync   = vs;
  endtask

  function automatic logic [7:0] pat(input int i, input int inc);
    return 8'(8'h10 * (i % 4 + 1) + inc * (i / 4));
  endfunction

  task automatic push_quad(input int q, input int inc, input logic first_line);
    exp_t e;
    e.u  = pat(q * 4, inc);
    e.y1 = pat(q * 4 + 1, inc);
    e.v  = pat(q * 4 + 2, inc);
    e.y2 = pat(q * 4 + 3, inc);
    e.ls = (q == 0);
    e.fs = (q == 0) && first_line;
    sb.push_back(e);
  endtask

  task automatic send_line(input int n, input int inc, input logic exp_on,
                           input logic first_line, input logic clr_on_fall);
    for (int i = 0; i < n; i++) begin
      cyc(pat(i, inc), 1'b1, 1'b0);
      if (exp_on && (i % 4 == 3)) push_quad(i / 4, inc, first_line);
    end
    cyc(8'h00, 1'b0, 1'b0);
    errclr = clr_on_fall;
    cyc(8'h00, 1'b0, 1'b0);
    errclr = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 errclr = 1'b1;
    @(posedge clk);
    #1 errclr = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_u"},  {24'd0, bus.u},  32'd0);
    check({tag, "_y1"}, {24'd0, bus.y1}, 32'd0);
    check({tag, "_v"},  {24'd0, bus.v},  32'd0);
    check({tag, "_y2"}, {24'd0, bus.y2}, 32'd0);
    check({tag, "_flags"}, {28'd0, bus.pixvalid, bus.framestart, bus.linestart, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.camdata = 8'h00;
    bus.href    = 1'b0;
    bus.vsync   = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b0;

    // bytes with no VSYNC falling edge since reset
    snap = pix_cnt;
    send_line(16, 1, 1'b0, 1'b0, 1'b0);
    check("no_arm_pix", pix_cnt - snap, 0);
    check_outputs_zero("no_arm");

    // two full lines of a frame
    vsync_pulse();
    snap = pix_cnt;
    send_line(16, 0, 1'b1, 1'b1, 1'b0);
    check("line0_pix", pix_cnt - snap, 4);
    send_line(16, 2, 1'b1, 1'b0, 1'b0);
    check("line1_pix", pix_cnt - snap, 8);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    check("frame_ok_err", {31'd0, err}, 32'd0);

    // short lines: partial quad dropped, err set/clear and set-wins
    vsync_pulse();
    snap = pix_cnt;
    send_line(6, 5, 1'b1, 1'b1, 1'b0);
    check("short_pix", pix_cnt - snap, 1);
    check("short_err", {31'd0, err}, {31'd0, CHK});
    clear_err();
    send_line(6, 7, 1'b1, 1'b0, 1'b1);
    check("short2_pix", pix_cnt - snap, 2);
    check("set_wins_err", {31'd0, err}, {31'd0, CHK});
    clear_err();

    // reset pulse in the middle of the second quad
    vsync_pulse();
    snap = pix_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc(pat(i, 9), 1'b1, 1'b0);
      if (i == 3) push_quad(0, 9, 1'b1);
    end
    cyc(pat(5, 9), 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 6; i < 16; i++) cyc(pat(i, 9), 1'b1, 1'b0);
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
    check("post_rst_pix", pix_cnt - snap, 1);
    vsync_pulse();
    send_line(16, 3, 1'b1, 1'b1, 1'b0);
    check("rearm_pix", pix_cnt - snap, 5);

    // VSYNC rises mid-quad on the second line
    vsync_pulse();
    snap = pix_cnt;
    send_line(16, 1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(pat(i, 4), 1'b1, 1'b0);
      if (i == 3) push_quad(0, 4, 1'b0);
    end
    cyc(pat(6, 4), 1'b1, 1'b1);
    cyc(pat(7, 4), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(pat(i, 6), 1'b1, 1'b1);
    repeat (3) cyc(8'h00, 1'b0, 1'b1);
    check("vsync_abort_pix", pix_cnt - snap, 5);
    check("vsync_abort_err", {31'd0, err}, {31'd0, CHK});
    repeat (3) cyc(8'h00, 1'b0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
